// File: rtl/pipeline_ctrl.sv
// Pipeline control: turns hazard requests and cache hits into latch enables/flushes, PC enable, halt FSM and perf counters.
// Latency: enables/flushes are combinational from state and inputs; state, halted and counters update on the next CLK edge.
// Backpressure: a data miss freezes every latch and the PC until dhit; requests raised during a freeze are re-presented, not latched.
module pipeline_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             lw_nop,
    input  logic             jmp_flush,
    input  logic             brch_flush,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmem_req,
    input  logic             halt_in,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALTED  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             stall_inc, flush_inc;

    // Next-state and latch controls; the first matching rule wins, everything defaults to a full freeze.
    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        case (state_q)
            RUN, MEMWAIT: begin
                if (halt_in) begin
                    // Halt cycle freezes but is deliberately not counted as a stall.
                    state_d = HALTED;
                end else if (dmem_req && !dhit) begin
                    state_d   = MEMWAIT;
                    stall_inc = 1'b1;
                end else begin
                    // Covers the dhit cycle of MEMWAIT too, so there is no dead cycle on return.
                    state_d = RUN;
                    if (jmp_flush || brch_flush) begin
                        // Redirect beats a load-use stall: the stalled instruction is on the wrong path.
                        pc_en      = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        flush_inc  = 1'b1;
                    end else if (lw_nop) begin
                        idex_flush = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        stall_inc  = 1'b1;
                    end else if (!ihit) begin
                        ifid_flush = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        stall_inc  = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        // Keep every latch quiet while reset is held, independent of the clock.
        if (!nRST) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
        end
    end

    // Saturating counter and sticky halt next-state.
    always_comb begin
        halted_d = halted_q | (state_d == HALTED);
        stall_d  = (stall_inc && stall_q != CNT_MAX) ? stall_q + CNT_ONE : stall_q;
        flush_d  = (flush_inc && flush_q != CNT_MAX) ? flush_q + CNT_ONE : flush_q;
    end

    // State, halt flag and counters; asynchronous clear.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
        end
    end

    assign halted    = halted_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule
